// File: rtl/demux_stream_pkg.sv
// Shared definitions for the 1:2 stream demux: route encoding, FSM states
// and the per-output buffer depth.
package demux_stream_pkg;
  localparam logic ROUTE_A = 1'b0;
  localparam logic ROUTE_B = 1'b1;

  localparam int SLICE_DEPTH = 2;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;
endpackage

// File: rtl/demux_stream_if.sv
// Valid/ready stream bundle with {data, last}; master drives the beat,
// slave drives ready.
interface demux_stream_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             last;
  logic             ready;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/demux_slice.sv
// 2-entry {data, last} FIFO; a beat is visible one cycle after push.
// Ready comes from the registered count only, so a full slice takes a pop but no push.
module demux_slice
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  output logic             slice_ready,
  demux_stream_if.master   out_s
);
  localparam logic [1:0] FULL = 2'(SLICE_DEPTH);

  logic [WIDTH:0] mem [SLICE_DEPTH];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     count;
  logic           do_push;
  logic           do_pop;

  assign slice_ready = (count != FULL);
  assign do_push     = push && slice_ready;
  assign do_pop      = (count != 2'd0) && out_s.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLICE_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_s.valid = (count != 2'd0);
  assign {out_s.last, out_s.data} = mem[rd_ptr];
endmodule

// File: rtl/demux_stream.sv
// 1:2 packet demux: SEL picks A/B on a packet's first beat and the route holds until in_last.
// One cycle to an empty output; input ready follows only the selected slice's registered fill.
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           SEL,
  demux_stream_if.slave  in_s,
  demux_stream_if.master out_a,
  demux_stream_if.master out_b,
  output logic           busy,
  output logic           route
);
  state_t state;
  state_t state_nxt;
  logic   route_q;
  logic   route_nxt;
  logic   route_eff;
  logic   accept;
  logic   rdy_a;
  logic   rdy_b;
  logic   push_a;
  logic   push_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      route_q <= ROUTE_A;
    end else begin
      state   <= state_nxt;
      route_q <= route_nxt;
    end
  end

  assign route_eff = (state == LOCKED) ? route_q : SEL;
  assign in_s.ready = ~rst && ((route_eff == ROUTE_B) ? rdy_b : rdy_a);
  assign accept    = in_s.valid && in_s.ready;

  always_comb begin
    state_nxt = state;
    route_nxt = route_q;
    case (state)
      IDLE: begin
        // Single-beat packets never leave IDLE.
        if (accept && !in_s.last) begin
          state_nxt = LOCKED;
          route_nxt = SEL;
        end
      end
      LOCKED: begin
        if (accept && in_s.last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push_a = accept && (route_eff == ROUTE_A);
  assign push_b = accept && (route_eff == ROUTE_B);
  assign busy   = (state == LOCKED);
  assign route  = route_eff;

  demux_slice #(.WIDTH(WIDTH)) u_slice_a (
    .clk         (clk),
    .rst         (rst),
    .push        (push_a),
    .push_data   (in_s.data),
    .push_last   (in_s.last),
    .slice_ready (rdy_a),
    .out_s       (out_a)
  );

  demux_slice #(.WIDTH(WIDTH)) u_slice_b (
    .clk         (clk),
    .rst         (rst),
    .push        (push_b),
    .push_data   (in_s.data),
    .push_last   (in_s.last),
    .slice_ready (rdy_b),
    .out_s       (out_b)
  );
endmodule
